// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a 1-cycle-latency registered memory.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_funct3,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_write,
  output logic [2:0]    mem_funct3,
  output logic [AW-1:0] mem_write_address,
  output logic [31:0]   mem_write_data,
  output logic [AW-1:0] mem_read_address,
  input  logic [31:0]   mem_read_data
);

  typedef enum logic [1:0] {IDLE, IF_RD, D_RD, D_WR} state_t;

  state_t state;
  logic   fetch_win;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign fetch_win = if_req && (!d_req || starve_cnt == 4'(STARVE_MAX));

  // Counts data grants that made a pending fetch wait; any fetch grant restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt && if_req && starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign fetch_win = if_req && !d_req;
`endif

  assign if_gnt = (state == IDLE) && fetch_win;
  assign d_gnt  = (state == IDLE) && d_req && !fetch_win;

  // Memory data is already registered, so it is forwarded only in the response cycle.
  assign if_rdata = if_rvalid ? mem_read_data : 32'h0;
  assign d_rdata  = d_rvalid  ? mem_read_data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      mem_write         <= 1'b0;
      if_rvalid         <= 1'b0;
      d_rvalid          <= 1'b0;
      mem_funct3        <= 3'b010;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_write_data    <= 32'h0;
    end else begin
      mem_write <= 1'b0;
      if_rvalid <= (state == IF_RD);
      d_rvalid  <= (state == D_RD);
      case (state)
        IDLE: begin
          if (if_gnt) begin
            state            <= IF_RD;
            mem_read_address <= if_addr;
            mem_funct3       <= 3'b010;
          end else if (d_gnt) begin
            mem_funct3 <= d_funct3;
            if (d_we) begin
              state             <= D_WR;
              mem_write         <= 1'b1;
              mem_write_address <= d_addr;
              mem_write_data    <= d_wdata;
            end else begin
              state            <= D_RD;
              mem_read_address <= d_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [2:0]    d_funct3 = 3'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = 32'h0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_write;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_write_address, mem_read_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data = 32'h0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory and the bench's own copy of what it should hold.
  logic [31:0] mem [0:63];
  logic [31:0] model_mem [0:63];
  always @(posedge clk) begin
    mem_read_data <= mem[mem_read_address[7:2]];
    if (mem_write) mem[mem_write_address[7:2]] <= mem_write_data;
  end

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    int          g;      // cycle of the grant
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic        emw, eirv, edrv;
    logic [31:0] w_addr, w_data, if_exp, d_exp;
    logic [2:0]  w_f3;
    if (mon_en && rst_n) begin
      emw = 1'b0; eirv = 1'b0; edrv = 1'b0;
      w_addr = '0; w_data = '0; w_f3 = '0; if_exp = '0; d_exp = '0;
      foreach (q[i]) begin
        if (cyc == q[i].g + 1) begin
          if (q[i].kind == 2) begin
            emw = 1'b1; w_addr = q[i].addr; w_data = q[i].data; w_f3 = q[i].f3;
          end else begin
            chk("rd_addr", mem_read_address, q[i].addr);
            chk("rd_funct3", 32'(mem_funct3), 32'(q[i].f3));
          end
        end
        if (cyc == q[i].g + 2 && q[i].kind == 0) begin eirv = 1'b1; if_exp = q[i].data; end
        if (cyc == q[i].g + 2 && q[i].kind == 1) begin edrv = 1'b1; d_exp = q[i].data; end
      end
      chk("mem_write", 32'(mem_write), 32'(emw));
      if (emw) begin
        chk("wr_addr", mem_write_address, w_addr);
        chk("wr_data", mem_write_data, w_data);
        chk("wr_funct3", 32'(mem_funct3), 32'(w_f3));
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(eirv));
      if (eirv) chk("if_rdata", if_rdata, if_exp);
      chk("d_rvalid", 32'(d_rvalid), 32'(edrv));
      if (edrv) chk("d_rdata", d_rdata, d_exp);
      while (q.size() > 0 && cyc >= q[0].g + ((q[0].kind == 2) ? 1 : 2)) void'(q.pop_front());
    end
  end

  // Requester-side state: a request stays up with stable fields until granted.
  logic if_pend = 1'b0, d_pend = 1'b0;
  logic act_if, act_d;
  int   last_g = -100;
  int   starve_cnt = 0;

  task automatic issue_fetch(input logic [31:0] a);
    if_pend = 1'b1; if_addr = a;
  endtask

  task automatic issue_data(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    d_pend = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic issue_rand_data();
    issue_data(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_addr(), $urandom);
  endtask

  // One cycle: present requests, predict the grant from the arbitration rules, record expectations.
  task automatic tick();
    logic free, sw, eif, ed;
    if_req = if_pend;
    d_req  = d_pend;
    #1;
    free = (cyc != last_g + 1);
    sw = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    sw = (starve_cnt == STARVE_MAX);
`endif
    eif = free && if_pend && (!d_pend || sw);
    ed  = free && d_pend && !eif;
    chk("grant", {30'b0, if_gnt, d_gnt}, {30'b0, eif, ed});
    act_if = if_gnt;
    act_d  = d_gnt;
    if (eif) begin
      q.push_back('{0, cyc, if_addr, model_mem[if_addr[7:2]], 3'b010});
      last_g = cyc;
      starve_cnt = 0;
    end
    if (ed) begin
      last_g = cyc;
      if (if_pend && starve_cnt < 15) starve_cnt++;
      if (d_we) begin
        q.push_back('{2, cyc, d_addr, d_wdata, d_funct3});
        model_mem[d_addr[7:2]] = d_wdata;
      end else begin
        q.push_back('{1, cyc, d_addr, model_mem[d_addr[7:2]], d_funct3});
      end
    end
    @(negedge clk);
    if (eif) if_pend = 1'b0;
    if (ed)  d_pend  = 1'b0;
  endtask

  task automatic drain();
    if_pend = 1'b0;
    d_pend  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_funct3"}, 32'(mem_funct3), 32'd2);
    chk({tag, "_rd_addr"}, mem_read_address, 32'd0);
    chk({tag, "_wr_addr"}, mem_write_address, 32'd0);
    chk({tag, "_wr_data"}, mem_write_data, 32'd0);
  endtask

  initial begin
    int n, first_if;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    mem[4] = 32'h00500093;
    model_mem[4] = 32'h00500093;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Both requesters held high from reset: count grants until the first fetch grant.
    issue_fetch(32'h40);
    n = 0;
    first_if = 0;
    for (int i = 0; i < 2 * (STARVE_MAX + 2); i++) begin
      if (!d_pend) issue_rand_data();
      tick();
      if (act_if || act_d) n++;
      if (act_if && first_if == 0) first_if = n;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_first_fetch", 32'(first_if), 32'(STARVE_MAX + 1));
`else
    chk("starve_first_fetch", 32'(first_if), 32'd0);
`endif
    drain();

    issue_fetch(32'h10);
    repeat (4) tick();
    issue_fetch(32'h20);
    issue_data(1'b0, 3'b010, 32'h200, 32'h0);
    repeat (6) tick();
    issue_data(1'b1, 3'b010, 32'h204, 32'hDEADBEEF);
    repeat (2) tick();
    issue_data(1'b0, 3'b010, 32'h204, 32'h0);
    repeat (4) tick();

    for (int i = 0; i < 400; i++) begin
      if (if_pend && $urandom_range(0, 15) == 0) if_pend = 1'b0;
      if (!if_pend && $urandom_range(0, 2) == 0) issue_fetch(rand_addr());
      if (!d_pend && $urandom_range(0, 1) == 0) issue_rand_data();
      tick();
    end
    drain();

    // Abort a fetch while it is reading memory.
    issue_fetch(32'h30);
    tick();
    #2;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    last_g = -100;
    starve_cnt = 0;
    if_pend = 1'b0;
    d_pend = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk("midreset_if_rvalid_hold", 32'(if_rvalid), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    issue_fetch(32'h10);
    tick();
    chk("gnt_after_reset", 32'(act_if), 32'd1);
    repeat (4) tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
